// File: rtl/fifo_arb_pkg.sv
// Shared arbiter state encoding and default parameter values.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLOCK = 2'd2
  } state_t;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr, first set req wins.
// Output is one-hot, or zero when no request is present.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin N:1 arbiter feeding a FIFO write port; accepted word appears registered one cycle later.
// Grants stall while the FIFO is full, or almost full with a write already in flight.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_WIDTH-1:0]          wr_cnt,
  output logic                          ovf_err
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         last_grant;
  logic [NUM_REQ-1:0]    grant;
  logic                  block;
  logic                  transfer;
  logic [IW-1:0]         sel_idx;
  logic [FIFO_WIDTH-1:0] sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (last_grant),
    .grant (grant)
  );

  // The in-flight write counts against almost-full so a new grant can never land on a full FIFO.
  assign block = fifo_full | (fifo_almostfull & fifo_wr_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE:  if (arb_en) state_nxt = ST_RUN;
      ST_RUN:   if (block)  state_nxt = ST_BLOCK;
      ST_BLOCK: if (!block) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!arb_en) state_nxt = ST_IDLE;
    if (state == ST_RUN && !block && arb_en) req_ready = grant;
  end

  assign transfer = |req_ready;

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_idx  = IW'(i);
        sel_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= IW'(NUM_REQ - 1);
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
    end else begin
      fifo_wr_en <= transfer;
      if (transfer) begin
        last_grant   <= sel_idx;
        fifo_data_in <= sel_data;
        grant_id     <= sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (fifo_wr_ack)   wr_cnt  <= wr_cnt + CNT_WIDTH'(1);
      if (fifo_overflow) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench with a depth-8 FIFO model and a payload scoreboard for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  localparam int FW = 16;
  localparam int NR = 4;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           arb_en;
  logic [NR-1:0]  req_valid;
  logic [NR*FW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic [FW-1:0]  fifo_data_in;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic           fifo_almostfull;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic [1:0]     grant_id;
  logic [CW-1:0]  wr_cnt;
  logic           ovf_err;

  logic [3:0]     m_cnt;
  logic           m_ack;
  logic           m_ovf;
  logic           ovf_force;
  logic           ovf_seen;

  typedef struct {
    int        id;
    logic [FW-1:0] dat;
  } sb_t;

  sb_t sb[$];
  int  glog[$];
  int  m_last;
  int  tests_run = 0;
  int  tests_failed = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.FIFO_WIDTH(FW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arb_en          (arb_en),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_data_in    (fifo_data_in),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .grant_id        (grant_id),
    .wr_cnt          (wr_cnt),
    .ovf_err         (ovf_err)
  );

  // Depth-8 FIFO with no reads; ack and overflow report one cycle after the write strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 4'd0;
      m_ack <= 1'b0;
      m_ovf <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      m_ovf <= 1'b0;
      if (fifo_wr_en) begin
        if (m_cnt < 4'd8) begin
          m_cnt <= m_cnt + 4'd1;
          m_ack <= 1'b1;
        end else begin
          m_ovf <= 1'b1;
        end
      end
    end
  end

  assign fifo_full       = (m_cnt == 4'd8);
  assign fifo_almostfull = (m_cnt >= 4'd7);
  assign fifo_wr_ack     = m_ack;
  assign fifo_overflow   = m_ovf | ovf_force;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int n = -1;
    int hits = 0;
    for (int i = 0; i < NR; i++) begin
      if (((v >> i) & 4'b0001) != 4'b0000) begin
        n = i;
        hits++;
      end
    end
    return (hits == 1) ? n : -1;
  endfunction

  // Returns at posedge+1: grant checked/pushed at the negedge, write popped/compared after the edge.
  task automatic tick();
    int e;
    logic [NR-1:0] one;
    logic [NR-1:0] exp_vec;
    sb_t ent;
    one = 4'b0001;
    @(negedge clk);
    if (fifo_overflow === 1'b1 && ovf_force === 1'b0) ovf_seen = 1'b1;
    if (req_ready !== '0) begin
      e = rr_pick(req_valid, m_last);
      exp_vec = (e >= 0) ? (one << e) : '0;
      check("grant_onehot", 32'(req_ready), 32'(exp_vec));
      glog.push_back(onehot_idx(req_ready));
      if (e >= 0) begin
        ent.id  = e;
        ent.dat = req_data[e*FW +: FW];
        sb.push_back(ent);
        m_last = e;
      end
    end
    @(posedge clk);
    #1;
    if (fifo_wr_en === 1'b1) begin
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        check("sb_grant_id", 32'(grant_id), 32'(ent.id));
        check("sb_data", 32'(fifo_data_in), 32'(ent.dat));
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    sb.delete();
    glog.delete();
    m_last = NR - 1;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b1;
    req_valid = 4'b1111;
    ovf_force = 1'b0;
    ovf_seen  = 1'b0;
    m_last    = NR - 1;
    for (int i = 0; i < NR; i++) req_data[i*FW +: FW] = FW'(16'h1000 + i);

    // Reset state, with requests and enable already asserted.
    #12;
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_data", 32'(fifo_data_in), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_ovf_err", 32'(ovf_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    arb_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin burst into an empty depth-8 FIFO until it blocks.
    arb_en = 1'b1;
    #1;
    check("idle_no_grant", 32'(req_ready), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("burst_grant_present", 32'(|req_ready), 32'd1);
      tick();
      if (i == 0) check("wr_en_after_first", 32'(fifo_wr_en), 32'd1);
    end
    for (int j = 0; j < 3; j++) begin
      check("blocked_ready", 32'(req_ready), 32'd0);
      tick();
    end
    check("burst_len", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check("rr_order", 32'(glog[i]), 32'(i % NR));
    check("wr_cnt_8", 32'(wr_cnt), 32'd8);
    check("no_overflow_seen", 32'(ovf_seen), 32'd0);
    check("ovf_err_clear", 32'(ovf_err), 32'd0);

    // Single requester 2 with a distinctive payload.
    arb_en    = 1'b0;
    req_valid = 4'b0000;
    pulse_reset();
    req_data[2*FW +: FW] = 16'hA5A5;
    req_valid = 4'b0100;
    arb_en    = 1'b1;
    #1;
    check("single_idle", 32'(req_ready), 32'd0);
    tick();
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    check("single_data", 32'(fifo_data_in), 32'hA5A5);
    check("single_id", 32'(grant_id), 32'd2);
    check("single_wr_en", 32'(fifo_wr_en), 32'd1);
    req_valid = 4'b0000;

    // Enable dropped right after a transfer.
    req_valid = 4'b0001;
    #1;
    check("pre_drop_ready", 32'(req_ready), 32'h1);
    tick();
    arb_en = 1'b0;
    #1;
    check("drop_no_grant", 32'(req_ready), 32'd0);
    check("drop_inflight_wr", 32'(fifo_wr_en), 32'd1);
    check("drop_inflight_id", 32'(grant_id), 32'd0);
    tick();
    arb_en = 1'b1;
    #1;
    check("drop_idle_ready", 32'(req_ready), 32'd0);
    check("drop_wr_done", 32'(fifo_wr_en), 32'd0);
    tick();
    check("rerun_ready", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    tick();

    // Sticky overflow flag.
    ovf_force = 1'b1;
    tick();
    ovf_force = 1'b0;
    check("ovf_set", 32'(ovf_err), 32'd1);
    tick();
    tick();
    tick();
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    pulse_reset();
    #1;
    check("ovf_cleared_by_rst", 32'(ovf_err), 32'd0);
    tick();

    // Asynchronous reset in the middle of a burst.
    req_valid = 4'b1111;
    arb_en    = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_wr_en", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    glog.delete();
    m_last = NR - 1;
    #1;
    check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("mid_rst_data", 32'(fifo_data_in), 32'd0);
    check("mid_rst_id", 32'(grant_id), 32'd0);
    check("mid_rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 32'(req_ready), 32'd0);
    tick();
    check("post_rst_first", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
